fpu_result_stage: RTL
=====================

// Module: fpu_result_stage
// PURPOSE
//  Output stage directly downstream of the FPU exception unit. Assembles the final IEEE-754
//  single-precision word from normaliser result plus exception controls, packs the fflags vector,
//  buffers results in a 2-entry valid/ready queue toward the core, and keeps sticky fflags.
// PARAMETERS
//  C_TAG_W      4             width of the opaque op tag passed through with each result
//  C_NAN_CANON  32'h7FC00000  word emitted for every invalid (IV) float result
// PORTS
//  Clk_CI          in   1          clock
//  Rst_RI          in   1          asynchronous, active-high reset
//  Valid_SI        in   1          upstream result valid
//  Ready_SO        out  1          stage can accept (registered; 1 when fewer than 2 entries)
//  Tag_DI          in   C_TAG_W    op tag
//  Op_SI           in   C_CMD      operation code
//  Sign_res_DI     in   1          result sign
//  Exp_res_DI      in   C_EXP      normalised exponent
//  Mant_norm_DI    in   C_MANT+1   normalised mantissa, hidden bit at [C_MANT]
//  Int_res_DI      in   32         F2I integer result
//  Exp_toZero_SI   in   1          force exponent to zero
//  Exp_toInf_SI    in   1          force exponent to all-ones
//  Mant_toZero_SI  in   1          force mantissa to zero
//  IV_SI/OF_SI/UF_SI/IX_SI  in 1  exception flags
//  Flush_SI        in   1          discard all buffered results
//  Valid_SO        out  1          head entry valid
//  Ready_SI        in   1          consumer accepts head
//  Result_DO       out  32         head result word
//  Flags_DO        out  5          head flags {NV,DZ,OF,UF,NX}
//  Tag_DO          out  C_TAG_W    head tag
//  Fflags_we_SI    in   1          CSR write of sticky flags
//  Fflags_wdata_DI in   5          CSR write data
//  Fflags_DO       out  5          sticky flags
// BEHAVIOUR
//  Reset: Valid_SO=0, Ready_SO=1, Result_DO=0, Flags_DO=0, Tag_DO=0, Fflags_DO=0, queue empty.
//  Assembly, combinational on input:
//  - Op==C_FPU_F2I_CMD: word = Int_res_DI.
//  - else IV_SI: word = C_NAN_CANON.
//  - else exp = Exp_toInf ? C_EXP_INF : Exp_toZero ? C_EXP_ZERO : Exp_res.
//  - else mant = (Mant_toZero|Exp_toInf) ? 0 : Mant_norm[C_MANT-1:0].
//  - else word = {Sign_res_DI, exp, mant}.
//  - flags = {IV,1'b0,OF,UF,IX}. DZ is always 0 (no divider).
//  Push on Valid_SI&Ready_SO; pop on Valid_SO&Ready_SI. Latency 1 cycle: pushed in cycle N,
//  visible at Valid_SO in N+1 when empty. Order strictly FIFO.
//  Ready_SO is registered = (count_next<2). With 2 entries plus a pop, Ready_SO stays 0 that cycle
//  and is 1 the next cycle. No combinational Ready_SI->Ready_SO path.
//  Simultaneous push+pop with 1 entry: count stays 1, new entry becomes head next cycle.
//  Output regs hold while Valid_SO&~Ready_SI; they are stable until popped.
//  Flush_SI: next cycle count=0, Valid_SO=0, Ready_SO=1. A push or pop in the flush cycle is
//  discarded/ignored and does not touch sticky flags.
//  Sticky: on pop, Fflags |= head flags. On Fflags_we_SI, Fflags = wdata | (popped flags that cycle).
//  Pointers are 1 bit and wrap naturally; count is 2 bits, 0..2.
// STRUCTURE
//  fpu_defs package gains:
//  - C_FFLAG_NV/DZ/OF/UF/NX bit indices
//  - C_NAN_CANON_DEF
//  - typedef struct packed {word, flags, tag} fpu_res_t
//  Sub-module fpu_res_fifo: 2-entry fpu_res_t queue with count, flush, registered ready.
//  Top module holds the assembly logic and the sticky register.
// TESTING
//  - ADD, exp=8'h80, mant=24'hC00000, sign=0, no flags; Ready_SI=1 -> next cycle
//    Result_DO=32'h40400000, Flags_DO=0.
//  - Exp_toInf=1, Mant_toZero=1, OF=1, IX=1, sign=1 -> 32'hFF800000, Flags 5'b00101,
//    Fflags becomes 5'b00101 after pop.
//  - IV=1 on MUL (Inf*0) -> 32'h7FC00000, Flags 5'b10000; F2I with Int_res=32'h7FFFFFFF,
//    IV=1 -> 32'h7FFFFFFF.
//  - Ready_SI=0, push 3 back-to-back -> Ready_SO=0 after 2; third held upstream; release
//    Ready_SI -> results in order.
//  - Full queue + Flush_SI -> Valid_SO=0, Ready_SO=1 next cycle, Fflags unchanged.
//  - Fflags_we_SI with wdata=0 in the same cycle as pop of flags 5'b00001 -> Fflags_DO=5'b00001.
//  - Assert Rst_RI mid-stream -> all outputs at reset values immediately (async).

Source files
------------

// File: rtl/fpu_defs.sv
// fpu_defs: shared FPU encodings, flag positions and the result-stage entry type.
package fpu_defs;
  localparam int C_CMD = 4;
  localparam int C_EXP = 8;
  localparam int C_MANT = 23;
  localparam logic [C_CMD-1:0] C_FPU_ADD_CMD = 4'd0;
  localparam logic [C_CMD-1:0] C_FPU_SUB_CMD = 4'd1;
  localparam logic [C_CMD-1:0] C_FPU_MUL_CMD = 4'd2;
  localparam logic [C_CMD-1:0] C_FPU_I2F_CMD = 4'd3;
  localparam logic [C_CMD-1:0] C_FPU_F2I_CMD = 4'd4;
  localparam logic [C_EXP-1:0] C_EXP_INF = '1;
  localparam logic [C_EXP-1:0] C_EXP_ZERO = '0;
  localparam int C_FFLAG_NV = 4;
  localparam int C_FFLAG_DZ = 3;
  localparam int C_FFLAG_OF = 2;
  localparam int C_FFLAG_UF = 1;
  localparam int C_FFLAG_NX = 0;
  localparam logic [31:0] C_NAN_CANON_DEF = 32'h7FC00000;
  localparam int C_TAG_W_DEF = 4;
  typedef struct packed {
    logic [31:0] word;
    logic [4:0] flags;
    logic [C_TAG_W_DEF-1:0] tag;
  } fpu_res_t;
endpackage

// File: rtl/fpu_res_fifo.sv
// fpu_res_fifo: 2-entry result queue with flush and a registered push-side ready.
module fpu_res_fifo
  import fpu_defs::*;
#(
  parameter type T = fpu_res_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push_valid,
  output logic push_ready,
  input  T     push_data,
  input  logic flush,
  output logic pop_valid,
  input  logic pop_ready,
  output T     pop_data
);
  T mem [2];
  logic [1:0] count, count_next;
  logic wptr, rptr, push, pop;
  assign pop_valid = count != 2'd0;
  assign pop_data = mem[rptr];
  assign push = push_valid & push_ready & ~flush;
  assign pop = pop_valid & pop_ready & ~flush;
  assign count_next = flush ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
  // ready looks only at the next count, so consumer ready never reaches it combinationally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 2'd0;
      wptr <= 1'b0;
      rptr <= 1'b0;
      push_ready <= 1'b1;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      count <= count_next;
      push_ready <= count_next < 2'd2;
      if (flush) begin
        wptr <= 1'b0;
        rptr <= 1'b0;
      end else begin
        if (push) begin
          mem[wptr] <= push_data;
          wptr <= ~wptr;
        end
        if (pop) rptr <= ~rptr;
      end
    end
  end
endmodule

// File: rtl/fpu_result_stage.sv
// fpu_result_stage: assembles the final float/int result word and flags, queues them, keeps sticky fflags.
module fpu_result_stage
  import fpu_defs::*;
#(
  parameter int C_TAG_W = C_TAG_W_DEF,
  parameter logic [31:0] C_NAN_CANON = C_NAN_CANON_DEF
) (
  input  logic               Clk_CI,
  input  logic               Rst_RI,
  input  logic               Valid_SI,
  output logic               Ready_SO,
  input  logic [C_TAG_W-1:0] Tag_DI,
  input  logic [C_CMD-1:0]   Op_SI,
  input  logic               Sign_res_DI,
  input  logic [C_EXP-1:0]   Exp_res_DI,
  input  logic [C_MANT:0]    Mant_norm_DI,
  input  logic [31:0]        Int_res_DI,
  input  logic               Exp_toZero_SI,
  input  logic               Exp_toInf_SI,
  input  logic               Mant_toZero_SI,
  input  logic               IV_SI,
  input  logic               OF_SI,
  input  logic               UF_SI,
  input  logic               IX_SI,
  input  logic               Flush_SI,
  output logic               Valid_SO,
  input  logic               Ready_SI,
  output logic [31:0]        Result_DO,
  output logic [4:0]         Flags_DO,
  output logic [C_TAG_W-1:0] Tag_DO,
  input  logic               Fflags_we_SI,
  input  logic [4:0]         Fflags_wdata_DI,
  output logic [4:0]         Fflags_DO
);
  typedef struct packed {
    logic [31:0] word;
    logic [4:0] flags;
    logic [C_TAG_W-1:0] tag;
  } res_t;
  res_t in_res, head;
  logic [C_EXP-1:0] exp_fin;
  logic [C_MANT-1:0] mant_fin;
  logic [4:0] flags, pop_flags;
  assign exp_fin = Exp_toInf_SI ? C_EXP_INF : Exp_toZero_SI ? C_EXP_ZERO : Exp_res_DI;
  assign mant_fin = (Mant_toZero_SI | Exp_toInf_SI) ? '0 : Mant_norm_DI[C_MANT-1:0];
  always_comb begin
    flags = '0;
    flags[C_FFLAG_NV] = IV_SI;
    flags[C_FFLAG_OF] = OF_SI;
    flags[C_FFLAG_UF] = UF_SI;
    flags[C_FFLAG_NX] = IX_SI;
  end
  assign in_res.word = (Op_SI == C_FPU_F2I_CMD) ? Int_res_DI :
                       IV_SI ? C_NAN_CANON : {Sign_res_DI, exp_fin, mant_fin};
  assign in_res.flags = flags;
  assign in_res.tag = Tag_DI;
  fpu_res_fifo #(.T(res_t)) u_fifo (
    .clk(Clk_CI),
    .rst(Rst_RI),
    .push_valid(Valid_SI),
    .push_ready(Ready_SO),
    .push_data(in_res),
    .flush(Flush_SI),
    .pop_valid(Valid_SO),
    .pop_ready(Ready_SI),
    .pop_data(head)
  );
  assign Result_DO = head.word;
  assign Flags_DO = head.flags;
  assign Tag_DO = head.tag;
  assign pop_flags = (Valid_SO & Ready_SI & ~Flush_SI) ? head.flags : 5'd0;
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) Fflags_DO <= 5'd0;
    else Fflags_DO <= (Fflags_we_SI ? Fflags_wdata_DI : Fflags_DO) | pop_flags;
  end
endmodule
